reg_file_swap: RTL and testbench

Parametrised successor to the 4x8 accumulator-style register file.
- Generalised data width and depth.
- Synchronous clear of all registers on reset.
- Optional write-to-read bypass.
- Serialised two-cycle register SWAP through a holding register, with busy/done handshake.
Sits between the decoder/ALU writeback and the ALU operand muxes. dat0_out feeds the implicit-accumulator path.

---
 rtl/reg_file_pkg.sv | 15 +
 rtl/reg_file_swap.sv | 116 +++++++++++
 tb/tb_reg_file_swap.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared definitions for the swap-capable register file.
// Provides default data/address widths (shared with the decoder) and the
// swap sequencer state type.
package reg_file_pkg;

   localparam int unsigned DEF_DW = 8;
   localparam int unsigned DEF_AW = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWAP1 = 2'd1,
      SWAP2 = 2'd2
   } swap_state_t;

endpackage : reg_file_pkg

// File: rtl/reg_file_swap.sv
// Parametrised register file with optional write-through bypass and a
// serialised two-cycle SWAP of two registers through a holding register.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   dat_in/wr_en/wr_addr: write port (accepted only in IDLE without swap_req)
//   rd_addrA/rd_addrB   : combinational read addresses, also swap operands
//   swap_req            : request swap of core[rd_addrA] and core[rd_addrB]
//   datA_out/datB_out   : combinational read data (bypass when BYPASS=1)
//   dat0_out            : core[0], never bypassed (accumulator path)
//   busy                : high while the swap sequence runs
//   swap_done           : one-cycle pulse on the first IDLE cycle after a swap
module reg_file_swap
   import reg_file_pkg::*;
#(
   parameter int unsigned DW     = DEF_DW,
   parameter int unsigned AW     = DEF_AW,
   parameter bit          BYPASS = 1'b1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] dat_in,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [AW-1:0] rd_addrA,
   input  logic [AW-1:0] rd_addrB,
   input  logic          swap_req,
   output logic [DW-1:0] datA_out,
   output logic [DW-1:0] datB_out,
   output logic [DW-1:0] dat0_out,
   output logic          busy,
   output logic          swap_done
);

   localparam int unsigned NREGS = 2 ** AW;

   logic [DW-1:0] core_q [NREGS];
   logic [DW-1:0] core_d [NREGS];
   swap_state_t   state_q, state_d;
   logic [AW-1:0] sa_q, sa_d;
   logic [AW-1:0] sb_q, sb_d;
   logic [DW-1:0] hold_q, hold_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          wr_hit;

   // Next-state: storage updates and swap sequencing
   always_comb begin
      core_d  = core_q;
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      hold_d  = hold_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            // A swap request wins over a same-cycle write
            if (swap_req) begin
               sa_d    = rd_addrA;
               sb_d    = rd_addrB;
               hold_d  = core_q[rd_addrA];
               state_d = SWAP1;
               busy_d  = 1'b1;
            end else if (wr_en) begin
               core_d[wr_addr] = dat_in;
            end
         end
         SWAP1: begin
            core_d[sa_q] = core_q[sb_q];
            state_d      = SWAP2;
            busy_d       = 1'b1;
         end
         SWAP2: begin
            core_d[sb_q] = hold_q;
            state_d      = IDLE;
            done_d       = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers; reset clears everything and aborts a running swap
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            core_q[i] <= '0;
         end
         state_q <= IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         hold_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         core_q  <= core_d;
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         hold_q  <= hold_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Write-through only for a write that will actually be accepted
   assign wr_hit = BYPASS && (state_q == IDLE) && wr_en && !swap_req;

   assign datA_out  = (wr_hit && (wr_addr == rd_addrA)) ? dat_in : core_q[rd_addrA];
   assign datB_out  = (wr_hit && (wr_addr == rd_addrB)) ? dat_in : core_q[rd_addrB];
   assign dat0_out  = core_q[0];
   assign busy      = busy_q;
   assign swap_done = done_q;

endmodule : reg_file_swap

// File: tb/tb_reg_file_swap.sv
// Self-checking bench for reg_file_swap: a BYPASS=1 and a BYPASS=0 instance
// share one stimulus stream and one behavioural model; a 16x16 instance
// checks the parametrised build.
module tb_reg_file_swap;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   // shared 8-bit / 4-entry stimulus
   logic       reset;
   logic [7:0] din;
   logic       wen;
   logic [1:0] waddr, ra, rb;
   logic       sreq;
   logic [7:0] qa, qb, q0, nqa, nqb, nq0;
   logic       busy, done, nbusy, ndone;

   // wide build stimulus
   logic [15:0] w_din;
   logic        w_wen, w_sreq;
   logic [3:0]  w_waddr, w_ra, w_rb;
   logic [15:0] w_qa, w_qb, w_q0;
   logic        w_busy, w_done;

   int nchecks = 0;
   int nerrors = 0;

   reg_file_swap #(.DW(8), .AW(2), .BYPASS(1'b1)) u_byp (
      .clk(clk), .reset(reset), .dat_in(din), .wr_en(wen), .wr_addr(waddr),
      .rd_addrA(ra), .rd_addrB(rb), .swap_req(sreq),
      .datA_out(qa), .datB_out(qb), .dat0_out(q0), .busy(busy), .swap_done(done));

   reg_file_swap #(.DW(8), .AW(2), .BYPASS(1'b0)) u_nobyp (
      .clk(clk), .reset(reset), .dat_in(din), .wr_en(wen), .wr_addr(waddr),
      .rd_addrA(ra), .rd_addrB(rb), .swap_req(sreq),
      .datA_out(nqa), .datB_out(nqb), .dat0_out(nq0), .busy(nbusy), .swap_done(ndone));

   reg_file_swap #(.DW(16), .AW(4), .BYPASS(1'b1)) u_wide (
      .clk(clk), .reset(reset), .dat_in(w_din), .wr_en(w_wen), .wr_addr(w_waddr),
      .rd_addrA(w_ra), .rd_addrB(w_rb), .swap_req(w_sreq),
      .datA_out(w_qa), .datB_out(w_qb), .dat0_out(w_q0), .busy(w_busy), .swap_done(w_done));

   // Behavioural model: register contents plus the swap phase (0 = idle)
   logic [7:0] m [4];
   int         ph;
   logic [1:0] msa, msb;
   logic [7:0] mhold;
   logic       mdone;

   function automatic logic [7:0] exp_rd(input logic [1:0] a, input bit byp);
      if (byp && ph == 0 && wen && !sreq && waddr == a) return din;
      return m[a];
   endfunction

   task automatic model_edge();
      if (reset) begin
         for (int i = 0; i < 4; i++) m[i] = 8'h00;
         ph = 0; mdone = 1'b0; msa = 2'd0; msb = 2'd0; mhold = 8'h00;
      end else begin
         mdone = (ph == 2);
         if (ph == 0) begin
            if (sreq) begin
               msa = ra; msb = rb; mhold = m[ra]; ph = 1;
            end else if (wen) begin
               m[waddr] = din;
            end
         end else if (ph == 1) begin
            m[msa] = m[msb]; ph = 2;
         end else begin
            m[msb] = mhold; ph = 0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      wen = 1'b0; sreq = 1'b0; din = 8'h00; waddr = 2'd0; ra = 2'd0; rb = 2'd0;
   endtask

   task automatic write(input logic [1:0] a, input logic [7:0] d);
      wen = 1'b1; waddr = a; din = d; sreq = 1'b0;
      tick();
      wen = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; idle_inputs();
      w_din = '0; w_wen = 1'b0; w_sreq = 1'b0; w_waddr = '0; w_ra = '0; w_rb = '0;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) write(2'(i), 8'hA5);
      ra = 2'd3; #1;
      nchecks++; if (qa !== 8'hA5) begin nerrors++; $display("FAIL reset_pre_write r3: got %h want a5", qa); end
      // reset overrides a same-cycle write
      reset = 1'b1; wen = 1'b1; waddr = 2'd1; din = 8'h5A;
      tick();
      reset = 1'b0; wen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ra = 2'(i); rb = 2'(i); #1;
         nchecks++; if (qa !== 8'h00 || nqb !== 8'h00) begin nerrors++; $display("FAIL reset_clear r%0d: got %h/%h want 00", i, qa, nqb); end
      end
      nchecks++; if (busy !== 1'b0 || done !== 1'b0) begin nerrors++; $display("FAIL reset_flags: busy=%b done=%b want 0/0", busy, done); end
   endtask

   task automatic test_bypass();
      wen = 1'b1; waddr = 2'd2; din = 8'h3C; ra = 2'd2; rb = 2'd1; #1;
      nchecks++; if (qa !== 8'h3C) begin nerrors++; $display("FAIL bypass_same_cycle: got %h want 3c", qa); end
      nchecks++; if (nqa !== exp_rd(2'd2, 1'b0)) begin nerrors++; $display("FAIL nobypass_same_cycle: got %h want %h", nqa, exp_rd(2'd2, 1'b0)); end
      tick();
      wen = 1'b0; #1;
      nchecks++; if (qa !== 8'h3C || nqa !== 8'h3C) begin nerrors++; $display("FAIL bypass_next_cycle: got %h/%h want 3c", qa, nqa); end
   endtask

   task automatic test_swap();
      write(2'd1, 8'h11); write(2'd3, 8'h33); write(2'd0, 8'h5A);
      ra = 2'd1; rb = 2'd3; sreq = 1'b1;
      tick();
      sreq = 1'b0; #1;
      nchecks++; if (busy !== 1'b1 || qa !== 8'h11) begin nerrors++; $display("FAIL swap_s1: busy=%b r1=%h want 1/11", busy, qa); end
      tick(); #1;
      nchecks++; if (busy !== 1'b1 || qa !== 8'h33 || qb !== 8'h33) begin nerrors++; $display("FAIL swap_s2: busy=%b r1=%h r3=%h want 1/33/33", busy, qa, qb); end
      tick(); #1;
      nchecks++; if (busy !== 1'b0 || done !== 1'b1 || qa !== 8'h33 || qb !== 8'h11 || q0 !== 8'h5A) begin
         nerrors++; $display("FAIL swap_done: busy=%b done=%b r1=%h r3=%h r0=%h want 0/1/33/11/5a", busy, done, qa, qb, q0); end
      tick(); #1;
      nchecks++; if (done !== 1'b0) begin nerrors++; $display("FAIL swap_done_width: done=%b want 0", done); end
   endtask

   task automatic test_conflict();
      int ndone_seen = 0;
      ra = 2'd1; rb = 2'd0; sreq = 1'b1; wen = 1'b1; waddr = 2'd1; din = 8'hFF; #1;
      nchecks++; if (qa !== m[1] || qa === 8'hFF) begin nerrors++; $display("FAIL conflict_no_bypass: got %h want %h", qa, m[1]); end
      tick();
      // write and swap requests while busy must be ignored
      wen = 1'b1; waddr = 2'd0; din = 8'hEE; sreq = 1'b1;
      tick(); if (done) ndone_seen++;
      tick();
      wen = 1'b0; sreq = 1'b0; #1;
      if (done) ndone_seen++;
      nchecks++; if (q0 !== 8'h33 || q0 !== m[0]) begin nerrors++; $display("FAIL busy_write_ignored r0: got %h want 33", q0); end
      ra = 2'd1; #1;
      nchecks++; if (qa !== 8'h5A) begin nerrors++; $display("FAIL conflict_write_dropped r1: got %h want 5a", qa); end
      for (int i = 0; i < 3; i++) begin tick(); if (done) ndone_seen++; end
      nchecks++; if (ndone_seen != 1 || busy !== 1'b0) begin nerrors++; $display("FAIL busy_swap_ignored: dones=%0d busy=%b want 1/0", ndone_seen, busy); end
   endtask

   task automatic test_self_swap();
      int ndone_seen = 0;
      write(2'd2, 8'h77);
      ra = 2'd2; rb = 2'd2; sreq = 1'b1;
      tick();
      sreq = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (done) ndone_seen++;
         nchecks++; if (qa !== 8'h77) begin nerrors++; $display("FAIL self_swap cyc%0d: got %h want 77", i, qa); end
         tick();
      end
      nchecks++; if (ndone_seen != 1) begin nerrors++; $display("FAIL self_swap_done: pulses=%0d want 1", ndone_seen); end
   endtask

   task automatic test_reset_abort();
      ra = 2'd1; rb = 2'd2; sreq = 1'b1;
      tick();
      sreq = 1'b0; reset = 1'b1;
      tick();
      reset = 1'b0; #1;
      nchecks++; if (busy !== 1'b0 || done !== 1'b0) begin nerrors++; $display("FAIL abort_flags: busy=%b done=%b want 0/0", busy, done); end
      for (int i = 0; i < 4; i++) begin
         ra = 2'(i); #1;
         nchecks++; if (qa !== 8'h00) begin nerrors++; $display("FAIL abort_clear r%0d: got %h want 00", i, qa); end
      end
      tick(); tick(); #1;
      nchecks++; if (done !== 1'b0 || busy !== 1'b0) begin nerrors++; $display("FAIL abort_no_done: done=%b busy=%b want 0/0", done, busy); end
   endtask

   task automatic test_back_to_back();
      int ndone_seen = 0;
      write(2'd0, 8'hC1); write(2'd1, 8'hD2);
      ra = 2'd0; rb = 2'd1; sreq = 1'b1;
      for (int i = 0; i < 9; i++) begin tick(); if (done) ndone_seen++; end
      sreq = 1'b0; #1;
      nchecks++; if (ndone_seen != 3) begin nerrors++; $display("FAIL back_to_back: pulses=%0d want 3", ndone_seen); end
      // three swaps of the same pair leave them exchanged
      nchecks++; if (q0 !== 8'hD2 || qb !== 8'hC1) begin nerrors++; $display("FAIL back_to_back_data: r0=%h r1=%h want d2/c1", q0, qb); end
      tick();
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         reset = ($urandom_range(0, 59) == 0);
         wen   = !reset && ($urandom_range(0, 1) == 1);
         sreq  = !reset && ($urandom_range(0, 3) == 0);
         din   = 8'($urandom);
         waddr = 2'($urandom); ra = 2'($urandom); rb = 2'($urandom);
         #1;
         nchecks++; if (qa !== exp_rd(ra, 1'b1) || qb !== exp_rd(rb, 1'b1)) begin
            nerrors++; $display("FAIL rand_byp_read k=%0d: got %h/%h want %h/%h", k, qa, qb, exp_rd(ra, 1'b1), exp_rd(rb, 1'b1)); end
         nchecks++; if (nqa !== exp_rd(ra, 1'b0) || nqb !== exp_rd(rb, 1'b0)) begin
            nerrors++; $display("FAIL rand_nobyp_read k=%0d: got %h/%h want %h/%h", k, nqa, nqb, exp_rd(ra, 1'b0), exp_rd(rb, 1'b0)); end
         nchecks++; if (q0 !== m[0] || nq0 !== m[0]) begin
            nerrors++; $display("FAIL rand_r0 k=%0d: got %h/%h want %h", k, q0, nq0, m[0]); end
         nchecks++; if (busy !== (ph != 0) || done !== mdone || nbusy !== (ph != 0) || ndone !== mdone) begin
            nerrors++; $display("FAIL rand_flags k=%0d: busy=%b done=%b want %b/%b", k, busy, done, ph != 0, mdone); end
         tick();
      end
      reset = 1'b0; idle_inputs();
      for (int i = 0; i < 3; i++) tick();
   endtask

   task automatic test_wide();
      w_wen = 1'b1; w_waddr = 4'd0;  w_din = 16'hBEEF; tick();
      w_waddr = 4'd15; w_din = 16'h1234; tick();
      w_wen = 1'b0; #1;
      nchecks++; if (w_q0 !== 16'hBEEF) begin nerrors++; $display("FAIL wide_write r0: got %h want beef", w_q0); end
      w_ra = 4'd0; w_rb = 4'd15; w_sreq = 1'b1;
      tick();
      w_sreq = 1'b0; #1;
      nchecks++; if (w_busy !== 1'b1) begin nerrors++; $display("FAIL wide_busy: got %b want 1", w_busy); end
      tick(); tick(); #1;
      nchecks++; if (w_done !== 1'b1 || w_q0 !== 16'h1234 || w_qb !== 16'hBEEF) begin
         nerrors++; $display("FAIL wide_swap: done=%b r0=%h r15=%h want 1/1234/beef", w_done, w_q0, w_qb); end
      tick();
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_swap();
      test_conflict();
      test_self_swap();
      test_reset_abort();
      test_back_to_back();
      test_random();
      test_wide();
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule : tb_reg_file_swap
